// File: rtl/psum_drain_if.sv
// Handshake bundle between the column-bottom drain and its neighbours.
// Carries the carry-save psum input and the resolved valid/ready output.
interface psum_drain_if #(
  parameter int W = 20
);
  logic         in_valid;
  logic [W-1:0] psum0;
  logic [W-1:0] psum1;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_ovf;

  // The drain itself sits on the slave side.
  modport slave (
    input  in_valid, psum0, psum1, out_ready,
    output out_valid, out_data, out_ovf
  );

  modport master (
    output in_valid, psum0, psum1, out_ready,
    input  out_valid, out_data, out_ovf
  );
endinterface

// File: rtl/psum_drain.sv
// Column-bottom drain: resolves the carry-save psum pair into a two's-complement
// sum, then buffers results in a first-word-fall-through FIFO with drop flagging.
module psum_drain #(
  parameter int SIZE  = 4,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       clr,
  psum_drain_if.slave                bus,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       drop
);
  localparam int W  = SIZE + 16;
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W:0]    w_sum;
  logic          r_stg_v;
  logic [W-1:0]  r_stg_data;
  logic          r_stg_ovf;

  logic [W:0]    r_mem [DEPTH];
  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          r_drop;

  logic          w_full;
  logic          w_valid;
  logic          w_pop;
  logic          w_push;
  logic          w_lose;
  logic [W:0]    w_head;

  // One extra bit so the top two bits of the sum expose signed overflow.
  assign w_sum = {bus.psum0[W-1], bus.psum0} + {bus.psum1[W-1], bus.psum1};

  // Resolve stage: loads every cycle, the array upstream can never be stalled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_stg_v    <= 1'b0;
      r_stg_data <= '0;
      r_stg_ovf  <= 1'b0;
    end else if (clr) begin
      r_stg_v    <= 1'b0;
    end else begin
      r_stg_v <= bus.in_valid;
      if (bus.in_valid) begin
        r_stg_data <= w_sum[W-1:0];
        r_stg_ovf  <= w_sum[W] ^ w_sum[W-1];
      end
    end
  end

  assign w_full  = (r_count == FULL_CNT);
  assign w_valid = (r_count != '0);
  assign w_pop   = w_valid && bus.out_ready && !clr;
  // A full FIFO still accepts when the head leaves in the same cycle.
  assign w_push  = r_stg_v && (!w_full || w_pop) && !clr;
  assign w_lose  = r_stg_v && w_full && !w_pop && !clr;

  // NOTE: the storage array has no reset; occupancy and pointers define what is
  // live, and the head is masked to zero whenever the FIFO is empty.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {r_stg_ovf, r_stg_data};
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else if (clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
      if (w_lose) r_drop <= 1'b1;
    end
  end

  assign w_head        = r_mem[r_rd_ptr];
  assign bus.out_valid = w_valid;
  assign bus.out_data  = w_valid ? w_head[W-1:0] : '0;
  assign bus.out_ovf   = w_valid ? w_head[W]     : 1'b0;
  assign count         = r_count;
  assign full          = w_full;
  assign drop          = r_drop;
endmodule

// File: doc/psum_drain.md
# psum_drain

Column-bottom drain for the systolic array. Accepts the carry-save partial-sum pair (`psum0`/`psum1`) leaving the last PE of a column and resolves it to a two's-complement result with a carry-propagate add. Results are buffered in a small FIFO and delivered downstream over a valid/ready handshake. It is the consumer-side counterpart of the PE psum chain: the array never stalls, so back-pressure is absorbed here and any loss is flagged.

## Interface
- `SIZE`, default 4: array-size parameter; sets the psum bus width W = SIZE+16, matching the PE psum ports.
- `DEPTH`, default 4: FIFO entries; must be a power of 2, ≥ 2.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `clr`  in  1  synchronous flush: empties the stage and FIFO and clears `drop`.
- `in_valid`  in  1  `psum0`/`psum1` hold a valid column result this cycle.
- `psum0`  in  W  carry-save word 0 (signed).
- `psum1`  in  W  carry-save word 1 (signed).
- `out_valid`  out  1  FIFO head is valid.
- `out_ready`  in  1  downstream accepts the head this cycle.
- `out_data`  out  W  resolved sum at FIFO head, low W bits.
- `out_ovf`  out  1  head entry overflowed W-bit signed range.
- `count`  out  $clog2(DEPTH)+1  FIFO occupancy, 0..DEPTH.
- `full`  out  1  count == DEPTH.
- `drop`  out  1  sticky: a result was discarded because the FIFO was full.

## Operation
- Stage 1 (resolve):
  - On a clock edge with `in_valid`=1, register `s = sext(psum0) + sext(psum1)` at W+1 bits.
  - Store `data = s[W-1:0]` and `ovf = s[W] ^ s[W-1]`.
  - Set `stg_v` = `in_valid` every cycle; the stage always loads and is never stalled.
- Stage 2 (FIFO):
  - Push occurs when `stg_v`=1 and the FIFO is not full, or when it is full and a pop happens in the same cycle.
  - If `stg_v`=1, the FIFO is full, and there is no pop, the entry is discarded and `drop` is set to 1.
  - `drop` stays high until `rstn` or `clr`.
- Pop: occurs when `out_valid && out_ready`.
- Head is first-word-fall-through: `out_data`/`out_ovf` reflect the oldest entry whenever `out_valid`=1. Values when `out_valid`=0 are don't-care but stable.
- Simultaneous push and pop: `count` is unchanged, order is preserved. When empty, a same-cycle pop cannot occur because `out_valid`=0.
- Read and write pointers are log2(DEPTH) bits and wrap modulo DEPTH. `count` is tracked explicitly.
- `clr` has priority over everything:
  - After the edge: `stg_v`=0, FIFO empty, `drop`=0.
  - Any `in_valid` or pop in the `clr` cycle is ignored.
- No arithmetic saturation: overflow is reported via `out_ovf` only, and the data wraps.

## Timing
- Reset (`rstn`=0, async) drives:
  - `out_valid`=0, `count`=0, `full`=0, `drop`=0.
  - `out_data`=0, `out_ovf`=0, `stg_v`=0, pointers=0.
- Release is synchronous to `clk`.
- Latency: `in_valid` sampled at edge k → `stg_v`=1 after edge k → entry in FIFO after edge k+1. On an empty FIFO, `out_valid` rises 2 cycles after `in_valid`.
- Throughput: one result per cycle sustained while `out_ready`=1.
- `full` and `count` update on the edge of the push/pop; `full` is a decode of `count`.
- Reset asserted mid-operation: all entries are lost immediately, and no output is valid until new input arrives.

## Test plan
- Basic add (SIZE=4, W=20): `psum0`=20'h00005, `psum1`=20'h00003, `in_valid` for 1 cycle, `out_ready`=1 → `out_valid`=1 two cycles later, `out_data`=20'h00008, `out_ovf`=0, `count` returns to 0.
- Sign handling: `psum0`=20'hFFFFF, `psum1`=20'h00001 → `out_data`=20'h00000, `out_ovf`=0. Separately, `psum0`=20'hFFFFE, `psum1`=20'hFFFFD → `out_data`=20'hFFFFB.
- Overflow: `psum0`=20'h7FFFF, `psum1`=20'h00001 → `out_data`=20'h80000, `out_ovf`=1.
- Fill/drop: `out_ready`=0, 5 back-to-back inputs with sums 1..5, DEPTH=4 → `count`=4, `full`=1, `drop`=1. Then `out_ready`=1 → outputs 1,2,3,4 in order, then `out_valid`=0; `drop` stays 1.
- Full with simultaneous pop: FIFO full, `out_ready`=1 while continuous input streams → no drop, `count` stays 4, order preserved across pointer wrap for ≥ 12 entries.
- Reset/clear mid-operation:
  - FIFO holding 3 entries, `rstn` pulsed low between edges → all outputs zero immediately.
  - Repeat using `clr` → `count`=0 and `drop`=0 after the edge, and the input presented in the `clr` cycle never appears.
- Randomized: 100 random `psum0`/`psum1` pairs with random `out_ready`, checked against a reference model (sum low W bits, ovf, drop accounting).
